// File: rtl/priority_arbiter_rr.sv
// Registered N-way arbiter with a valid/ready grant port.
// Picks one winner by fixed MSB-first priority (RR=0) or round-robin (RR=1) and holds it until accepted.
module priority_arbiter_rr #(
  parameter int unsigned N  = 8,
  parameter bit          RR = 1'b0,
  localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         gnt_ready,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot,
  output logic         idle
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] idx_q, idx_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [N-1:0] oh_q, oh_d;
  logic         valid_q, valid_d;
  logic         idle_q, idle_d;
  logic         xfer;
  logic [W-1:0] ptr_next;
  logic [W-1:0] win_idx;

  // Winner selection; RR scans downward from p, wrapping 0 -> N-1, so p itself is top priority.
  function automatic logic [W-1:0] sel_fn(input logic [N-1:0] r, input logic [W-1:0] p);
    logic [W-1:0] win;
    logic [W-1:0] cidx;
    int           c;
    win  = '0;
    cidx = '0;
    if (!RR) begin
      for (int i = 0; i < int'(N); i++) begin
        if (r[W'(i)]) win = W'(i);
      end
    end else begin
      // Iterate lowest priority first so the last hit (k = 0, i.e. p) dominates.
      for (int k = int'(N) - 1; k >= 0; k--) begin
        c = int'(p) - k;
        if (c < 0) c = c + int'(N);
        cidx = W'(c);
        if (r[cidx]) win = cidx;
      end
    end
    return win;
  endfunction

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    oh_d     = oh_q;
    valid_d  = valid_q;
    idle_d   = idle_q;
    xfer     = valid_q & gnt_ready;
    ptr_next = ptr_q;
    if (RR && xfer) begin
      ptr_next = (idx_q == '0) ? W'(N - 1) : idx_q - W'(1);
    end
    ptr_d   = ptr_next;
    win_idx = sel_fn(req, ptr_next);

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_GRANT;
          idx_d   = win_idx;
          oh_d    = N'(1) << win_idx;
          valid_d = 1'b1;
          idle_d  = 1'b0;
        end
      end
      S_GRANT: begin
        if (xfer) begin
          if (|req) begin
            idx_d = win_idx;
            oh_d  = N'(1) << win_idx;
          end else begin
            state_d = S_IDLE;
            idx_d   = '0;
            oh_d    = '0;
            valid_d = 1'b0;
            idle_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        oh_d    = '0;
        valid_d = 1'b0;
        idle_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      oh_q    <= '0;
      ptr_q   <= W'(N - 1);
      valid_q <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      idle_q  <= idle_d;
    end
  end

  assign gnt_valid  = valid_q;
  assign gnt_idx    = idx_q;
  assign gnt_onehot = oh_q;
  assign idle       = idle_q;

endmodule
